// File: rtl/complex_mult_pkg.sv
// Shared types and constants for the complex multiply scheduler:
// FSM state encoding, datapath widths and operand offsets inside a requester slot.
package complex_mult_pkg;

    localparam int OP_W       = 8;
    localparam int RES_W      = 16;
    localparam int REQ_DATA_W = 32;

    // Slot layout is {op_1=A1, op_2=B1, op_3=A2, op_4=B2}
    localparam int OP1_OFS = 24;
    localparam int OP2_OFS = 16;
    localparam int OP3_OFS = 8;
    localparam int OP4_OFS = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M0   = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        RESP = 3'd5
    } state_t;

endpackage

// File: rtl/complex_mult_scheduler_if.sv
// Request/result bus of the complex multiply scheduler; slave side is the scheduler,
// master side is the requesting DSP stages plus the result consumer.
interface complex_mult_scheduler_if
    import complex_mult_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [REQ_DATA_W*NUM_REQ-1:0] req_data;
    logic                          res_valid;
    logic                          res_ready;
    logic [ID_W-1:0]               res_id;
    logic [RES_W-1:0]              real_part_num;
    logic [RES_W-1:0]              imag_part_num;
    logic                          busy;

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_id, real_part_num, imag_part_num, busy
    );

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_id, real_part_num, imag_part_num, busy
    );

endinterface

// File: rtl/complex_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after i_ptr,
// wrapping around; the pointer itself is owned by the caller.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_gidx,
    output logic               o_any
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_gidx  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(i_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_gidx         = w_idx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/complex_mult_scheduler.sv
// Time-shares one 8x8 multiplier across NUM_REQ requesters to form complex products.
// Optional macro CMS_SIGNED_EN: operands/results are two's-complement instead of unsigned.
module complex_mult_scheduler
    import complex_mult_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    complex_mult_scheduler_if.slave io_bus
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t                r_state, w_next;
    logic [NUM_REQ-1:0]    w_grant;
    logic [ID_W-1:0]       w_gidx;
    logic                  w_any;
    logic                  w_can_accept;
    logic                  w_accept;
    logic [REQ_DATA_W-1:0] w_sel_data;
    logic [OP_W-1:0]       w_mul_a, w_mul_b;
    logic [RES_W-1:0]      w_prod;

    logic [ID_W-1:0]       r_ptr, r_gid, r_res_id;
    logic [REQ_DATA_W-1:0] r_ops;
    logic [RES_W-1:0]      r_buff, r_real_tmp, r_real, r_imag;
    logic                  r_res_valid;

    function automatic logic [RES_W-1:0] mul8(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
`ifdef CMS_SIGNED_EN
        logic signed [RES_W-1:0] sa, sb;
        sa = {{(RES_W-OP_W){a[OP_W-1]}}, a};
        sb = {{(RES_W-OP_W){b[OP_W-1]}}, b};
        return sa * sb;
`else
        return {{(RES_W-OP_W){1'b0}}, a} * {{(RES_W-OP_W){1'b0}}, b};
`endif
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req   (io_bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_gidx  (w_gidx),
        .o_any   (w_any)
    );

    // Reset gates acceptance so the strobe reads 0 while reset is held
    assign w_can_accept     = !i_rst && ((r_state == IDLE) || (r_state == RESP && io_bus.res_ready));
    assign w_accept         = w_any && w_can_accept;
    assign io_bus.req_ready = w_accept ? w_grant : '0;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_data = w_sel_data | ({REQ_DATA_W{w_grant[i]}} & io_bus.req_data[i*REQ_DATA_W +: REQ_DATA_W]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = M0;
            M0:      w_next = M1;
            M1:      w_next = M2;
            M2:      w_next = M3;
            M3:      w_next = RESP;
            RESP:    if (io_bus.res_ready) w_next = w_accept ? M0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Single multiplier: operand pair selected by the step being executed
    always_comb begin
        w_mul_a = r_ops[OP1_OFS +: OP_W];
        w_mul_b = r_ops[OP3_OFS +: OP_W];
        case (r_state)
            M1:      begin w_mul_a = r_ops[OP2_OFS +: OP_W]; w_mul_b = r_ops[OP4_OFS +: OP_W]; end
            M2:      begin w_mul_a = r_ops[OP1_OFS +: OP_W]; w_mul_b = r_ops[OP4_OFS +: OP_W]; end
            M3:      begin w_mul_a = r_ops[OP2_OFS +: OP_W]; w_mul_b = r_ops[OP3_OFS +: OP_W]; end
            default: ;
        endcase
    end

    assign w_prod = mul8(w_mul_a, w_mul_b);

    // Real part is parked in r_real_tmp so the published outputs only change with a new result
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr       <= '0;
            r_gid       <= '0;
            r_ops       <= '0;
            r_buff      <= '0;
            r_real_tmp  <= '0;
            r_real      <= '0;
            r_imag      <= '0;
            r_res_id    <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ptr <= (w_gidx == ID_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
                r_gid <= w_gidx;
                r_ops <= w_sel_data;
            end
            case (r_state)
                M0:      r_buff     <= w_prod;
                M1:      r_real_tmp <= r_buff - w_prod;
                M2:      r_buff     <= w_prod;
                M3: begin
                    r_real   <= r_real_tmp;
                    r_imag   <= r_buff + w_prod;
                    r_res_id <= r_gid;
                end
                default: ;
            endcase
            if (r_state == M3)                          r_res_valid <= 1'b1;
            else if (r_res_valid && io_bus.res_ready)   r_res_valid <= 1'b0;
        end
    end

    assign io_bus.res_valid     = r_res_valid;
    assign io_bus.res_id        = r_res_id;
    assign io_bus.real_part_num = r_real;
    assign io_bus.imag_part_num = r_imag;
    assign io_bus.busy          = (r_state != IDLE);

endmodule

// File: doc/complex_mult_scheduler.md
# complex_mult_scheduler

Shares one 8×8 multiplier between NUM_REQ requesters that each need a complex product (A1 + jB1)·(A2 + jB2). A round-robin arbiter accepts one request at a time. A four-step FSM then runs the four partial products through the single multiplier. The block returns the real and imaginary parts together with the winning requester's ID over a valid/ready result port. It sits between the requesting DSP stages and the shared multiplier resource.

## Interface
- NUM_REQ, default 4: number of requesters, 2..16.
- ID_W, default $clog2(NUM_REQ): width of the requester ID; derived, not overridden.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester request valid.
- REQ_READY  out  NUM_REQ  per-requester accept strobe; at most one bit high.
- REQ_DATA  in  32·NUM_REQ  requester i occupies bits [32i+31:32i] as {op_1=A1, op_2=B1, op_3=A2, op_4=B2}, each 8 bit.
- RES_VALID  out  1  result valid.
- RES_READY  in  1  result consumer ready.
- RES_ID  out  ID_W  index of the requester that owns the result.
- REAL_PART_NUM  out  16  A1·A2 − B1·B2.
- IMAG_PART_NUM  out  16  A1·B2 + B1·A2.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE → M0 on accept.
  - M0 → M1 → M2 → M3 → RESP, one cycle each.
  - RESP → IDLE when RES_READY=1 and no new accept.
  - RESP → M0 when RES_READY=1 and a new accept occurs in the same cycle.
- Accept: REQ_READY[g]=1 combinationally when state is IDLE (or RESP with RES_READY=1), REQ_VALID[g]=1, and g is the grant. Operands and g are latched on that edge.
- Arbitration: round-robin starting at pointer PTR. Grant goes to the first set REQ_VALID bit at index ≥ PTR, wrapping. On accept, PTR ← (g+1) mod NUM_REQ.
- Multiplier input mux:
  - M0: A1·A2 → BUFF.
  - M1: REAL ← BUFF − B1·B2.
  - M2: A1·B2 → BUFF.
  - M3: IMAG ← BUFF + B1·A2; RES_VALID ← 1.
- Arithmetic: operands are unsigned 8-bit and products are 16-bit. Subtraction and addition are modulo 2^16 with no saturation and no overflow flag.
- REAL_PART_NUM, IMAG_PART_NUM and RES_ID are stable throughout RESP. They hold their last value after the handshake until the next result.
- RES_VALID drops on the edge where RES_VALID=1 and RES_READY=1, unless a new result lands on the same edge. That cannot happen, because the minimum spacing is 5 cycles.
- REQ_VALID dropping without an accept is legal; the request is simply ignored. REQ_DATA only needs to be valid in the accept cycle.

## Timing
- Reset values: state IDLE, PTR=0, RES_VALID=0, RES_ID=0, REAL_PART_NUM=0, IMAG_PART_NUM=0, BUSY=0, REQ_READY=0.
- Latency: the accept edge is E0. RES_VALID is high after E4, i.e. 4 cycles from accept to result.
- Throughput: with RES_READY held at 1, one result every 5 cycles (back-to-back accept in RESP).
- Back-pressure: with RES_READY=0, the FSM stalls in RESP indefinitely and REQ_READY stays 0.
- Reset mid-operation: the in-flight operation is discarded with no partial result and all registers return to their reset values immediately.

## Configuration
- Macro: CMS_SIGNED_EN.
- Defined: op_1..op_4 are two's-complement signed 8-bit values. Products are sign-extended signed 16-bit, and the results are signed 16-bit modulo 2^16.
- Undefined: everything is unsigned as described above.
- The macro changes nothing except arithmetic interpretation; timing and handshakes are identical.

## Structure
- Package complex_mult_pkg holds:
  - the FSM state enum (IDLE, M0, M1, M2, M3, RESP);
  - OP_W=8, RES_W=16, REQ_DATA_W=32;
  - the op field offsets within a requester slot.
- Sub-module rr_arbiter:
  - parameter NUM_REQ;
  - inputs: request vector and PTR;
  - outputs: one-hot grant, grant index, any_req;
  - purely combinational. The scheduler owns PTR.
- The multiplier mux, BUFF, output registers and FSM live in complex_mult_scheduler.

## Test plan
- Basic product: requester 0 sends (3+4j)·(5+2j), i.e. op=3,4,5,2, with RES_READY=1 → after 4 cycles RES_VALID=1, RES_ID=0, REAL=7, IMAG=26.
- Real-part wrap: op=1,10,1,10 → REAL=0xFF9D, IMAG=20. With CMS_SIGNED_EN, op=0xFF,0,0xFF,0 → REAL=0x0001 (without the macro, 0xFE01).
- Round-robin: all four REQ_VALID held high continuously → grants 0,1,2,3,0, one accept every 5 cycles, RES_ID sequence matches.
- Back-pressure: RES_READY=0 for 10 cycles after a result → outputs stable, BUSY=1, no REQ_READY. Then RES_READY=1 → one handshake, and the next pending request is accepted on the same edge.
- Reset mid-operation: assert RST during M2 → RES_VALID=0, outputs 0, PTR=0 immediately. A subsequent request yields a correct result with no stale BUFF data.
- Sparse requests: only requester 2 is valid while PTR=3 → wrap-around grant to 2; PTR then becomes 3.
